// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path types and constants.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetch entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, credit-limited imem requests, instruction
// buffer toward decode, and redirect handling with stale-response dropping.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemRespValid,
  input  logic [XLEN-1:0] imemRespData,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  output logic            instValid,
  input  logic            instReady,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instPc,
  output logic [XLEN-1:0] pcPlus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW:0]     credit_used;
  logic            req_fire, drop_resp, keep_resp, pop_fire;

  logic [XLEN-1:0] if_pc;
  logic            if_full, if_empty;
  logic [CW-1:0]   if_count;
  fetch_entry_t    ib_in, ib_out;
  logic            ib_full, ib_empty;
  logic [CW-1:0]   ib_count;
  logic            unused_ok;

  // Every request already in flight owns a buffer slot; a same-cycle pop is not credited.
  assign credit_used  = {1'b0, outstanding_q} + {1'b0, ib_count};
  assign imemReqValid = !Reset && !redirectValid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imemAddr     = pc_q;
  assign req_fire     = imemReqValid && imemReqReady;

  assign drop_resp = imemRespValid && (drop_q != '0);
  assign keep_resp = imemRespValid && !drop_resp;

  assign instValid = !Reset && !redirectValid && !ib_empty;
  assign pop_fire  = instValid && instReady;

  assign ib_in.pc    = if_pc;
  assign ib_in.instr = imemRespData;

  assign instruction = instValid ? ib_out.instr : NOP_INSTR;
  assign instPc      = instValid ? ib_out.pc : '0;
  assign pcPlus4     = instValid ? ib_out.pc + XLEN'(4) : '0;

  // Dropped responses belong to requests whose PCs were flushed on redirect,
  // so they never pop the in-flight queue.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_inflight (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (req_fire),
    .pop_i   (keep_resp),
    .flush_i (redirectValid),
    .data_i  (pc_q),
    .data_o  (if_pc),
    .full_o  (if_full),
    .empty_o (if_empty),
    .count_o (if_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (keep_resp && !redirectValid),
    .pop_i   (pop_fire),
    .flush_i (redirectValid),
    .data_i  (ib_in),
    .data_o  (ib_out),
    .full_o  (ib_full),
    .empty_o (ib_empty),
    .count_o (ib_count)
  );

  always_comb begin
    pc_d          = pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imemRespValid);
    if (redirectValid) begin
      pc_d   = {redirectPc[XLEN-1:2], 2'b00};
      drop_d = outstanding_q - CW'(imemRespValid);
    end else begin
      if (req_fire)  pc_d   = pc_q + XLEN'(4);
      if (drop_resp) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign unused_ok = ^{redirectPc[1:0], if_full, if_empty, if_count, ib_full};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a latency-modelling imem.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset, imemReqReady, imemRespValid, redirectValid, instReady;
  logic [31:0] imemRespData, redirectPc;
  logic        reqV, instV, reqV2, instV2;
  logic [31:0] addr, instr, ipc, pp4, addr2, instr2, ipc2, pp42;

  always #5 Clk = ~Clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .imemReqValid(reqV), .imemReqReady(imemReqReady),
    .imemAddr(addr), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .instValid(instV),
    .instReady(instReady), .instruction(instr), .instPc(ipc), .pcPlus4(pp4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .imemReqValid(reqV2), .imemReqReady(imemReqReady),
    .imemAddr(addr2), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .instValid(instV2),
    .instReady(instReady), .instruction(instr2), .instPc(ipc2), .pcPlus4(pp42)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pq[$];
  int          cyc = 0, last_due = 0, fixed_lat = 1;
  int          passed = 0, total = 0, acc_cnt = 0, pop_cnt = 0;
  logic [31:0] exp_pc = 32'h0, prev_addr = 32'h0;
  bit          prev_stall = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  // Drive this cycle's memory response, then check combinational outputs.
  task automatic tick_a();
    if (Reset) begin
      pq.delete();
      last_due = cyc;
    end
    if (!Reset && pq.size() > 0 && pq[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = mem_word(pq[0].addr);
      void'(pq.pop_front());
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = 32'h0;
    end
    #1;
    if (Reset || redirectValid) check("quiet", {reqV, instV}, 2'b00);
    if (prev_stall && !Reset && !redirectValid) check("addr_hold", {reqV, addr}, {1'b1, prev_addr});
    if (instV) begin
      check("instr", instr, mem_word(ipc));
      check("pc_plus4", pp4, ipc + 32'd4);
    end else begin
      check("idle_out", {instr, ipc, pp4}, 96'h0);
    end
  endtask

  // Scoreboard pops, record accepted requests, advance one clock.
  task automatic tick_b();
    int lat, due;
    if (instV && instReady) begin
      check("order", ipc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      pop_cnt++;
    end
    if (reqV && imemReqReady) begin
      lat = (fixed_lat == 0) ? int'($urandom_range(1, 5)) : fixed_lat;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pq.push_back('{addr: addr, due: due});
      acc_cnt++;
    end
    if (Reset) exp_pc = 32'h0;
    else if (redirectValid) exp_pc = {redirectPc[31:2], 2'b00};
    prev_stall = reqV && !imemReqReady && !redirectValid && !Reset;
    prev_addr  = addr;
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    redirectValid = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic rst, rdy, rv;
    logic [31:0] a;
    logic iv;
    logic [31:0] pc, p4, a2, p42;
  } vec_t;

  initial begin
    vec_t vt[9];
    bit   found;
    int   first;

    vt[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h00, 32'hFFFF_FFF8, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h00, 32'hFFFF_FFF8, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h00, 32'hFFFF_FFFC, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h04, 32'h0000_0000, 32'hFFFF_FFFC};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h08, 32'h0000_0004, 32'h0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h0C, 32'h0000_0008, 32'h4};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'hC, 32'h10, 32'h0000_000C, 32'h8};
    vt[7] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC, 32'h10, 32'h0000_0010, 32'h8};
    vt[8] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h14, 32'h0000_0014, 32'hC};

    Reset = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0;
    instReady = 1'b1; imemReqReady = 1'b1;
    imemRespValid = 1'b0; imemRespData = 32'h0;
    @(posedge Clk);
    @(negedge Clk);

    // Startup stream with 1-cycle memory, both reset PCs side by side.
    fixed_lat = 1;
    foreach (vt[i]) begin
      Reset = vt[i].rst;
      instReady = vt[i].rdy;
      tick_a();
      check($sformatf("vec%0d", i), {reqV, addr, instV, ipc, pp4, addr2, pp42},
            {vt[i].rv, vt[i].a, vt[i].iv, vt[i].pc, vt[i].p4, vt[i].a2, vt[i].p42});
      tick_b();
    end

    // Decode stalled: four requests fill the buffer, head stays put.
    do_reset();
    instReady = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick_a();
      if (i >= 2) check("stall_head", {instV, ipc}, {1'b1, 32'h0});
      tick_b();
    end
    check("stall_reqs", acc_cnt, 4);
    tick_a();
    check("stall_reqvalid", reqV, 1'b0);
    instReady = 1'b1;
    pop_cnt = 0;
    tick_b();
    for (int i = 0; i < 19; i++) tick();
    check("release_pops", pop_cnt, 20);
    check("release_next_pc", exp_pc, 32'd80);

    // Redirect with two requests in flight (3-cycle memory).
    fixed_lat = 3;
    do_reset();
    tick();
    tick();
    redirectValid = 1'b1; redirectPc = 32'h0000_1003;
    tick();
    redirectValid = 1'b0;
    tick_a();
    check("redir1_addr", {reqV, addr}, {1'b1, 32'h0000_1000});
    tick_b();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick_a();
      if (instV) begin
        found = 1'b1;
        check("redir1_pc", ipc, 32'h0000_1000);
      end
      tick_b();
    end
    check("redir1_seen", found, 1'b1);

    // Redirect coinciding with a response and a pending pop (2-cycle memory).
    fixed_lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    redirectValid = 1'b1; redirectPc = 32'h0000_2000;
    tick_a();
    check("redir2_ctx", imemRespValid, 1'b1);
    tick_b();
    redirectValid = 1'b0;
    found = 1'b0; first = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      tick_a();
      if (instV) begin
        found = 1'b1; first = k;
        check("redir2_pc", ipc, 32'h0000_2000);
      end
      tick_b();
    end
    check("redir2_latency", first, 4);

    // Random latency, request backpressure, decode stalls and redirects.
    fixed_lat = 0;
    do_reset();
    pop_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      imemReqReady  = ($urandom_range(0, 3) != 0);
      instReady     = ($urandom_range(0, 2) != 0);
      redirectValid = ($urandom_range(0, 49) == 0);
      redirectPc    = $urandom;
      tick();
    end
    check("rand_progress", pop_cnt > 50, 1'b1);
    redirectValid = 1'b0;
    Reset = 1'b1;
    tick_a();
    check("midrun_reset", {reqV, instV, instr, ipc, pp4}, 98'h0);
    tick_b();
    Reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      imemReqReady  = ($urandom_range(0, 3) != 0);
      instReady     = ($urandom_range(0, 2) != 0);
      redirectValid = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
